// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide sequencer:
// FSM state codes, operation encoding and the counter-width helper.
package muldiv_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Issue-side request/response bundle of the multiply/divide sequencer.
// The issuer holds a request until busy drops; no queuing behind busy.
interface muldiv_seq_if #(parameter int RV = 32);
  logic          start;
  logic          mult;
  logic          div;
  logic [RV-1:0] a;
  logic [RV-1:0] b;
  logic [3:0]    rd_in;
  logic          kill;
  logic          busy;
  logic          done;
  logic [RV-1:0] result;
  logic [3:0]    rd_out;
  logic          div_zero;

  modport master (
    output start, mult, div, a, b, rd_in, kill,
    input  busy, done, result, rd_out, div_zero
  );

  modport slave (
    input  start, mult, div, a, b, rd_in, kill,
    output busy, done, result, rd_out, div_zero
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// Zero latency; the sequencer registers every output.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int RV = 32
) (
  input  logic          op,
  input  logic [RV:0]   acc_rem,
  input  logic [RV-1:0] ma_dq,
  input  logic [RV-1:0] mb_dv,
  output logic [RV:0]   acc_rem_nxt,
  output logic [RV-1:0] ma_dq_nxt,
  output logic [RV-1:0] mb_dv_nxt
);

  logic [RV:0] rem_sh;
  logic [RV:0] rem_sub;

  always_comb begin
    acc_rem_nxt = acc_rem;
    ma_dq_nxt   = ma_dq;
    mb_dv_nxt   = mb_dv;
    rem_sh      = {acc_rem[RV-1:0], ma_dq[RV-1]};
    rem_sub     = rem_sh - {1'b0, mb_dv};
    if (op == OP_MUL) begin
      // Carry into the top bit is harmless: only the low RV bits are returned.
      acc_rem_nxt = acc_rem + {1'b0, (mb_dv[0] ? ma_dq : '0)};
      ma_dq_nxt   = ma_dq << 1;
      mb_dv_nxt   = mb_dv >> 1;
    end else if (rem_sh >= {1'b0, mb_dv}) begin
      acc_rem_nxt = rem_sub;
      ma_dq_nxt   = {ma_dq[RV-2:0], 1'b1};
    end else begin
      acc_rem_nxt = rem_sh;
      ma_dq_nxt   = {ma_dq[RV-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/DIVU sequencer: accept in IDLE, done RV+1 cycles later (1 for early outs).
// Requests arriving while busy are dropped; kill aborts to IDLE without a done.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int RV = 32
) (
  input logic        clk,
  input logic        reset_n,
  muldiv_seq_if.slave bus
);

  localparam int CW = clog2(RV);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          op;
  logic [RV:0]   acc_rem;
  logic [RV-1:0] ma_dq;
  logic [RV-1:0] mb_dv;
  logic [RV:0]   acc_rem_nxt;
  logic [RV-1:0] ma_dq_nxt;
  logic [RV-1:0] mb_dv_nxt;

  logic          busy_q;
  logic          done_q;
  logic [RV-1:0] result_q;
  logic [3:0]    rd_q;
  logic          dz_q;

  logic accept;
  logic sel_op;

  assign accept = bus.start & ~busy_q & ~bus.kill & (bus.mult | bus.div);
  assign sel_op = bus.mult ? OP_MUL : OP_DIV;

  muldiv_step #(.RV(RV)) u_step (
    .op          (op),
    .acc_rem     (acc_rem),
    .ma_dq       (ma_dq),
    .mb_dv       (mb_dv),
    .acc_rem_nxt (acc_rem_nxt),
    .ma_dq_nxt   (ma_dq_nxt),
    .mb_dv_nxt   (mb_dv_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= OP_MUL;
      acc_rem  <= '0;
      ma_dq    <= '0;
      mb_dv    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.kill) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              op      <= sel_op;
              acc_rem <= '0;
              ma_dq   <= bus.a;
              mb_dv   <= bus.b;
              rd_q    <= bus.rd_in;
              dz_q    <= 1'b0;
              cnt     <= CW'(RV - 1);
              busy_q  <= 1'b1;
              if (sel_op == OP_DIV && bus.b == '0) begin
                state    <= DONE;
                done_q   <= 1'b1;
                result_q <= '1;
                dz_q     <= 1'b1;
              end else if (sel_op == OP_MUL && (bus.a == '0 || bus.b == '0)) begin
                state    <= DONE;
                done_q   <= 1'b1;
                result_q <= '0;
              end else begin
                state <= RUN;
              end
            end
          end
          RUN: begin
            acc_rem <= acc_rem_nxt;
            ma_dq   <= ma_dq_nxt;
            mb_dv   <= mb_dv_nxt;
            cnt     <= cnt - 1'b1;
            // Final iteration: publish the step output directly so done lands at T+RV+1.
            if (cnt == '0) begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= (op == OP_MUL) ? acc_rem_nxt[RV-1:0] : ma_dq_nxt;
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.rd_out   = rd_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, multi-cycle
// busy/kill/reset sequences and randomized operations against an arithmetic model.
module tb_muldiv_seq;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  muldiv_seq_if #(.RV(32)) bus ();

  muldiv_seq #(.RV(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic        d;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
    logic [31:0] res;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Caller sits at the negedge of cycle n0 (cycle 1 = first cycle after accept).
  task automatic poll(input int n0, output int lat);
    lat = -1;
    for (int n = n0; n <= 80; n++) begin
      if (bus.done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic m, input logic d, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [3:0] rd, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.mult = m; bus.div = d;
    bus.a = aa; bus.b = bb; bus.rd_in = rd;
    @(negedge clk);
    bus.start = 1'b0; bus.mult = 1'b0; bus.div = 1'b0;
    poll(1, lat);
  endtask

  task automatic check_result(input string nm, input int lat, input int exp_lat,
                              input logic [31:0] res, input logic [3:0] rd, input logic dz);
    chk({nm, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({nm, ".result"}, 64'(bus.result), 64'(res));
    chk({nm, ".rd_out"}, 64'(bus.rd_out), 64'(rd));
    chk({nm, ".div_zero"}, 64'(bus.div_zero), 64'(dz));
    @(negedge clk);
    chk({nm, ".busy_after"}, 64'(bus.busy), 64'd0);
    chk({nm, ".result_hold"}, 64'(bus.result), 64'(res));
  endtask

  function automatic void model(input logic m, input logic d, input logic [31:0] aa,
                                input logic [31:0] bb, output logic [31:0] res,
                                output logic dz, output int lat);
    logic [63:0] p;
    dz  = 1'b0;
    lat = 33;
    res = '0;
    if (m) begin
      p   = 64'(aa) * 64'(bb);
      res = p[31:0];
      if (aa == 0 || bb == 0) lat = 1;
    end else if (d) begin
      if (bb == 0) begin
        res = 32'hFFFF_FFFF;
        dz  = 1'b1;
        lat = 1;
      end else begin
        res = aa / bb;
      end
    end
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] eres;
    logic        edz;
    int          elat;
    logic        rm;
    logic        rdv;
    logic [3:0]  rrd;

    tests = 0;
    fails = 0;

    tbl[0] = '{1'b1, 1'b0, 32'd7,          32'd6,          4'd9, 32'd42,         1'b0, 33};
    tbl[1] = '{1'b1, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd1, 32'd1,          1'b0, 33};
    tbl[2] = '{1'b1, 1'b0, 32'd0,          32'd5,          4'd2, 32'd0,          1'b0, 1};
    tbl[3] = '{1'b0, 1'b1, 32'd100,        32'd7,          4'd3, 32'd14,         1'b0, 33};
    tbl[4] = '{1'b0, 1'b1, 32'd5,          32'd9,          4'd4, 32'd0,          1'b0, 33};
    tbl[5] = '{1'b0, 1'b1, 32'd123,        32'd0,          4'd5, 32'hFFFF_FFFF,  1'b1, 1};
    tbl[6] = '{1'b1, 1'b1, 32'd6,          32'd3,          4'd6, 32'd18,         1'b0, 33};
    tbl[7] = '{1'b0, 1'b1, 32'hFFFF_FFFF,  32'd1,          4'd7, 32'hFFFF_FFFF,  1'b0, 33};
    tbl[8] = '{1'b1, 1'b0, 32'd5,          32'd0,          4'd8, 32'd0,          1'b0, 1};
    tbl[9] = '{1'b0, 1'b1, 32'd0,          32'd5,          4'd15, 32'd0,         1'b0, 33};

    reset_n = 1'b0;
    bus.start = 1'b0; bus.mult = 1'b0; bus.div = 1'b0; bus.kill = 1'b0;
    bus.a = '0; bus.b = '0; bus.rd_in = '0;
    repeat (3) @(negedge clk);
    chk("reset.outputs", 64'({bus.busy, bus.done, bus.div_zero, bus.rd_out, bus.result}), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].m, tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].rd, lat);
      check_result($sformatf("vec%0d", i), lat, tbl[i].lat, tbl[i].res, tbl[i].rd, tbl[i].dz);
    end

    // start with neither flag is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd4; bus.b = 32'd4; bus.rd_in = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    chk("noflag.busy", 64'(bus.busy), 64'd0);
    chk("noflag.done", 64'(bus.done), 64'd0);

    // kill together with start in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.mult = 1'b1; bus.kill = 1'b1; bus.a = 32'd2; bus.b = 32'd2;
    @(negedge clk);
    bus.start = 1'b0; bus.mult = 1'b0; bus.kill = 1'b0;
    chk("killstart.busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("killstart.done", 64'(bus.done), 64'd0);

    // second start while busy is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.mult = 1'b1; bus.a = 32'd7; bus.b = 32'd6; bus.rd_in = 4'd9;
    @(negedge clk);
    bus.start = 1'b0; bus.mult = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.mult = 1'b1; bus.a = 32'd3; bus.b = 32'd3; bus.rd_in = 4'd2;
    @(negedge clk);
    bus.start = 1'b0; bus.mult = 1'b0;
    poll(6, lat);
    check_result("busyign", lat, 33, 32'd42, 4'd9, 1'b0);

    // kill mid-RUN, then restart in the cycle after the kill
    @(negedge clk);
    bus.start = 1'b1; bus.mult = 1'b1; bus.a = 32'd100; bus.b = 32'd3; bus.rd_in = 4'd10;
    @(negedge clk);
    bus.start = 1'b0; bus.mult = 1'b0;
    repeat (9) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    chk("kill.busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b1; bus.mult = 1'b1; bus.a = 32'd3; bus.b = 32'd5; bus.rd_in = 4'd4;
    @(negedge clk);
    bus.start = 1'b0; bus.mult = 1'b0;
    poll(12, lat);
    check_result("killrestart", lat, 44, 32'd15, 4'd4, 1'b0);

    // randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rm  = 1'($urandom_range(0, 1));
      rdv = ($urandom_range(0, 7) == 0) ? 1'b1 : ~rm;
      ra  = ($urandom_range(0, 9) == 0) ? 32'd0 :
            ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 1000));
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
            ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(1, 300));
      rrd = 4'($urandom_range(0, 15));
      model(rm, rdv, ra, rb, eres, edz, elat);
      run_op(rm, rdv, ra, rb, rrd, lat);
      check_result($sformatf("rand%0d", i), lat, elat, eres, rrd, edz);
    end

    // asynchronous reset between clock edges during RUN
    @(negedge clk);
    bus.start = 1'b1; bus.div = 1'b1; bus.a = 32'd100; bus.b = 32'd7; bus.rd_in = 4'd12;
    @(negedge clk);
    bus.start = 1'b0; bus.div = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("asyncrst.outputs", 64'({bus.busy, bus.done, bus.div_zero, bus.rd_out, bus.result}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(1'b1, 1'b0, 32'd3, 32'd3, 4'd5, lat);
    check_result("postrst", lat, 33, 32'd9, 4'd5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
